// File: rtl/ds_pkg.sv
// Shared definitions for the parameterised raster downsampler.
//   DEF_*    : default frame geometry (800x600 active in an 840x640 frame)
//   cnt_w    : bit width of a counter that spans 0..total-1
//   phase_is : tests the low FACTOR_LOG2 bits of a position against a phase
package ds_pkg;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_H_TOTAL  = 840;
  localparam int DEF_V_TOTAL  = 640;

  function automatic int cnt_w(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  // With flog2 == 0 the mask is empty, so every position matches phase 0.
  function automatic logic phase_is(input logic [31:0] pos, input int flog2,
                                    input int ph);
    logic [31:0] mask;
    mask = (32'd1 << flog2) - 32'd1;
    return (pos & mask) == (32'(ph) & mask);
  endfunction

endpackage

// File: rtl/ds_line_acc.sv
// Line accumulator for block averaging: one entry per output column.
// Each write is a read-modify-write of the addressed entry in a single cycle;
// the entry's updated value is also captured in the registered output.
//   clock, reset : system clock, synchronous active-high reset (output only)
//   we           : perform the read-modify-write this cycle
//   clr          : treat the old entry as zero (first row of a block)
//   idx          : entry index (output column)
//   add          : value added to the entry
//   sum          : registered updated value of the last written entry
module ds_line_acc import ds_pkg::*; #(
  parameter int ENTRIES = 400,
  parameter int SUM_W   = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       we,
  input  logic                       clr,
  input  logic [cnt_w(ENTRIES)-1:0]  idx,
  input  logic [SUM_W-1:0]           add,
  output logic [SUM_W-1:0]           sum
);

  // Storage needs no reset: every entry is overwritten (clr) on the first
  // row of each block before it is ever read back.
  logic [SUM_W-1:0] mem [ENTRIES];
  logic [SUM_W-1:0] nxt;

  assign nxt = (clr ? '0 : mem[idx]) + add;

  always_ff @(posedge clock) begin
    if (we) mem[idx] <= nxt;
  end

  always_ff @(posedge clock) begin
    if (reset)   sum <= '0;
    else if (we) sum <= nxt;
  end

endmodule

// File: rtl/param_downsampler.sv
// Raster downsampler: decimates a pixel stream by F = 2^FACTOR_LOG2 in both
// axes, generating the blanking region from the total frame geometry.
// Build option DOWNSAMPLER_AVG_EN: emit the mean of each FxF block instead of
// point-sampling its top-left pixel.
//   clock, reset   : system clock, synchronous active-high reset
//   valid, data    : input pixel stream (valid ignored in blanking)
//   sync_clear     : frame resync, the current pixel is taken as (0,0)
//   dataout        : output pixel, 0 in blanking
//   validout       : output sample strobe
//   blankingregion : registered blanking flag of the sampled position
//   sof, eol       : first kept pixel of a frame / last kept pixel of a line
module param_downsampler import ds_pkg::*; #(
  parameter int DATA_W      = 8,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int FACTOR_LOG2 = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic              sync_clear,
  output logic [DATA_W-1:0] dataout,
  output logic              validout,
  output logic              blankingregion,
  output logic              sof,
  output logic              eol
);

  localparam int F  = 1 << FACTOR_LOG2;
  localparam int CW = cnt_w(H_TOTAL);
  localparam int RW = cnt_w(V_TOTAL);

  // Point sampling keeps the first pixel of each block; averaging emits on
  // the last one, once the whole block has been summed.
`ifdef DOWNSAMPLER_AVG_EN
  localparam int KEEP_PH = F - 1;
  localparam int EOL_COL = H_ACTIVE - 1;
`else
  localparam int KEEP_PH = 0;
  localparam int EOL_COL = H_ACTIVE - F;
`endif

  localparam logic [CW-1:0] COL_LAST = CW'(H_TOTAL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_TOTAL - 1);

  logic [CW-1:0] col, pcol, col_n;
  logic [RW-1:0] row, prow, row_n;
  logic          blank_c, adv, keep;

  // Resync substitutes (0,0) as the sampled position; advancing from there
  // yields col = adv ? 1 : 0, row = 0.
  assign pcol    = sync_clear ? '0 : col;
  assign prow    = sync_clear ? '0 : row;
  assign blank_c = (prow >= RW'(V_ACTIVE)) || (pcol >= CW'(H_ACTIVE));
  assign adv     = valid || blank_c;
  assign keep    = adv && phase_is(32'(pcol), FACTOR_LOG2, KEEP_PH)
                       && phase_is(32'(prow), FACTOR_LOG2, KEEP_PH);

  always_comb begin
    col_n = pcol;
    row_n = prow;
    if (adv) begin
      if (pcol == COL_LAST) begin
        col_n = '0;
        row_n = (prow == ROW_LAST) ? '0 : prow + 1'b1;
      end else begin
        col_n = pcol + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col            <= '0;
      row            <= '0;
      validout       <= 1'b0;
      blankingregion <= 1'b0;
      sof            <= 1'b0;
      eol            <= 1'b0;
    end else begin
      col            <= col_n;
      row            <= row_n;
      validout       <= keep;
      blankingregion <= blank_c;
      sof            <= keep && !blank_c && prow == RW'(KEEP_PH)
                                         && pcol == CW'(KEEP_PH);
      eol            <= keep && !blank_c && pcol == CW'(EOL_COL);
    end
  end

`ifdef DOWNSAMPLER_AVG_EN
  localparam int HS_W    = DATA_W + FACTOR_LOG2;
  localparam int SUM_W   = DATA_W + 2 * FACTOR_LOG2;
  localparam int ENTRIES = H_ACTIVE / F;
  localparam int IW      = cnt_w(ENTRIES);

  logic             act_pix;
  logic             col_first, col_last, row_first;
  logic [HS_W-1:0]  hsum, hrow;
  logic [SUM_W-1:0] acc_sum;
  logic [IW-1:0]    idx;

  assign act_pix   = valid && !blank_c;
  assign col_first = phase_is(32'(pcol), FACTOR_LOG2, 0);
  assign col_last  = phase_is(32'(pcol), FACTOR_LOG2, F - 1);
  assign row_first = phase_is(32'(prow), FACTOR_LOG2, 0);
  assign idx       = IW'(pcol >> FACTOR_LOG2);

  // Horizontal partial sum restarts on the first column of every block, so
  // a resync or reset needs no flush.
  assign hrow = (col_first ? '0 : hsum) + HS_W'(data);

  always_ff @(posedge clock) begin
    if (reset)        hsum <= '0;
    else if (act_pix) hsum <= hrow;
  end

  ds_line_acc #(
    .ENTRIES (ENTRIES),
    .SUM_W   (SUM_W)
  ) u_acc (
    .clock (clock),
    .reset (reset),
    .we    (act_pix && col_last),
    .clr   (row_first),
    .idx   (idx),
    .add   (SUM_W'(hrow)),
    .sum   (acc_sum)
  );

  // Mean = sum >> 2*FACTOR_LOG2, i.e. the top DATA_W bits of the sum. The
  // sum register is one cycle behind its pixel, same as the flags.
  assign dataout = blankingregion ? '0 : acc_sum[SUM_W-1 -: DATA_W];
`else
  always_ff @(posedge clock) begin
    if (reset) dataout <= '0;
    else       dataout <= blank_c ? '0 : data;
  end
`endif

endmodule

// File: tb/tb_param_downsampler.sv
// Bench for param_downsampler: two instances (F=2 and F=4 small geometries)
// share one stimulus stream. A reference model pushes the expected outputs
// of every cycle into a per-instance queue; they are popped and compared one
// cycle later. Directed checks cover the first pixel, strobe/eol counts,
// resync and the averaging example. Follows DOWNSAMPLER_AVG_EN if defined.
module tb_param_downsampler;

  typedef struct packed {
    logic       vo;
    logic       bl;
    logic       so;
    logic       eo;
    logic [7:0] d;
  } out_t;

  logic       clock, reset, valid, sync_clear;
  logic [7:0] data;
  logic [7:0] dataout0, dataout1;
  logic       validout0, blank0, sof0, eol0;
  logic       validout1, blank1, sof1, eol1;

  param_downsampler #(.DATA_W(8), .H_ACTIVE(16), .V_ACTIVE(6), .H_TOTAL(20),
                      .V_TOTAL(8), .FACTOR_LOG2(1)) dut0 (
    .clock(clock), .reset(reset), .valid(valid), .data(data),
    .sync_clear(sync_clear), .dataout(dataout0), .validout(validout0),
    .blankingregion(blank0), .sof(sof0), .eol(eol0));

  param_downsampler #(.DATA_W(8), .H_ACTIVE(16), .V_ACTIVE(8), .H_TOTAL(20),
                      .V_TOTAL(10), .FACTOR_LOG2(2)) dut1 (
    .clock(clock), .reset(reset), .valid(valid), .data(data),
    .sync_clear(sync_clear), .dataout(dataout1), .validout(validout1),
    .blankingregion(blank1), .sof(sof1), .eol(eol1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int HA[2] = '{16, 16};
  int VA[2] = '{6, 8};
  int HT[2] = '{20, 20};
  int VT[2] = '{8, 10};
  int FL[2] = '{1, 2};

  int mcol[2], mrow[2], mhs[2];
  int macc[2][8];
  out_t q0[$], q1[$];

  int ncmp = 0, nfail = 0, ncyc = 0;
  int str0 = 0, eolc0 = 0, str1 = 0, eolc1 = 0;

  task automatic model(input int k, input bit r, input bit v, input bit sc,
                       input int d, output out_t e);
    int f, pc, pr, s;
    bit bl, adv, keep;
    f = 1 << FL[k];
    e = '0;
    if (r) begin
      mcol[k] = 0; mrow[k] = 0; mhs[k] = 0;
      return;
    end
    pc  = sc ? 0 : mcol[k];
    pr  = sc ? 0 : mrow[k];
    bl  = (pr >= VA[k]) || (pc >= HA[k]);
    adv = v || bl;
`ifdef DOWNSAMPLER_AVG_EN
    keep = adv && (pc % f == f - 1) && (pr % f == f - 1);
    s = 0;
    if (v && !bl) begin
      if (pc % f == 0) mhs[k] = 0;
      mhs[k] += d;
      if (pc % f == f - 1) begin
        if (pr % f == 0) macc[k][pc / f] = 0;
        macc[k][pc / f] += mhs[k];
        s = macc[k][pc / f] >> (2 * FL[k]);
      end
    end
    e.d  = bl ? 8'd0 : 8'(s);
    e.so = keep && !bl && pr == f - 1 && pc == f - 1;
    e.eo = keep && !bl && pc == HA[k] - 1;
`else
    keep = adv && (pc % f == 0) && (pr % f == 0);
    e.d  = bl ? 8'd0 : 8'(d);
    e.so = keep && !bl && pr == 0 && pc == 0;
    e.eo = keep && !bl && pc == HA[k] - f;
`endif
    e.vo = keep;
    e.bl = bl;
    mcol[k] = pc;
    mrow[k] = pr;
    if (adv) begin
      if (pc == HT[k] - 1) begin
        mcol[k] = 0;
        mrow[k] = (pr == VT[k] - 1) ? 0 : pr + 1;
      end else begin
        mcol[k] = pc + 1;
      end
    end
  endtask

  task automatic chk(input int k, input out_t o);
    out_t e, om;
    e  = (k == 0) ? q0.pop_front() : q1.pop_front();
    om = o;
    // dataout is only defined on strobes and in blanking
    if (!(e.vo || e.bl)) begin
      om.d = 8'd0;
      e.d  = 8'd0;
    end
    ncmp++;
    assert (om === e) else begin
      nfail++;
      $error("FAIL dut%0d cycle %0d: got %h expected %h (vo,bl,sof,eol,data)",
             k, ncyc, om, e);
    end
  endtask

  task automatic dchk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit v, input bit sc, input logic [7:0] d);
    out_t e0, e1;
    reset = r; valid = v; sync_clear = sc; data = d;
    model(0, r, v, sc, int'(d), e0); q0.push_back(e0);
    model(1, r, v, sc, int'(d), e1); q1.push_back(e1);
    @(posedge clock); #1;
    ncyc++;
    chk(0, {validout0, blank0, sof0, eol0, dataout0});
    chk(1, {validout1, blank1, sof1, eol1, dataout1});
    if (validout0 && !blank0) str0++;
    if (eol0) eolc0++;
    if (validout1 && !blank1) str1++;
    if (eol1) eolc1++;
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; sync_clear = 1'b0; data = 8'd0;

    // reset state
    repeat (3) cyc(1, 0, 0, 8'd0);

    // a few pixels, then reset mid-line
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 8'(100 + i));
    cyc(1, 1, 0, 8'hAA);

    // first frame of continuous valid, data = column; count strobes/eol
    str0 = 0; eolc0 = 0; str1 = 0; eolc1 = 0;
    cyc(0, 1, 0, 8'd0);
`ifndef DOWNSAMPLER_AVG_EN
    dchk("first_validout", int'(validout0), 1);
    dchk("first_sof", int'(sof0), 1);
    dchk("first_data", int'(dataout0), 0);
`endif
    for (int i = 1; i < 160; i++) cyc(0, 1, 0, 8'(mcol[0]));
    dchk("dut0_frame_strobes", str0, 24);
    dchk("dut0_frame_eols", eolc0, 3);
    dchk("dut1_frame_strobes", str1, 8);
    dchk("dut1_frame_eols", eolc1, 2);
    for (int i = 0; i < 240; i++) cyc(0, 1, 0, 8'(mcol[0]));

    // valid toggling
    for (int i = 0; i < 400; i++) cyc(0, bit'(i % 2 == 0), 0, 8'($urandom));

    // valid low: only blanking advances
    for (int i = 0; i < 60; i++) cyc(0, 0, 0, 8'($urandom));
    for (int i = 0; i < 37; i++) cyc(0, 1, 0, 8'($urandom));

    // resync mid-line with valid
    cyc(0, 1, 1, 8'h5A);
`ifndef DOWNSAMPLER_AVG_EN
    dchk("resync_sof", int'(sof0), 1);
    dchk("resync_data", int'(dataout0), 'h5A);
`endif
    for (int i = 0; i < 50; i++) cyc(0, 1, 0, 8'(mcol[0]));

    // 2x2 block 10,20 / 30,41
    cyc(1, 0, 0, 8'd0);
    cyc(0, 1, 0, 8'd10);
`ifndef DOWNSAMPLER_AVG_EN
    dchk("block_point_data", int'(dataout0), 10);
`endif
    cyc(0, 1, 0, 8'd20);
    for (int i = 0; i < 14; i++) cyc(0, 1, 0, 8'd0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 8'd0);
    cyc(0, 1, 0, 8'd30);
    cyc(0, 1, 0, 8'd41);
`ifdef DOWNSAMPLER_AVG_EN
    dchk("block_avg_valid", int'(validout0), 1);
    dchk("block_avg_sof", int'(sof0), 1);
    dchk("block_avg_data", int'(dataout0), 25);
`endif

    // random traffic with occasional resync and reset
    for (int i = 0; i < 600; i++)
      cyc(bit'($urandom_range(199) == 0), bit'($urandom_range(3) != 0),
          bit'($urandom_range(49) == 0), 8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
